fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Front-end PC generator and I-cache fetch sequencer directly upstream of the two-slot fetch FIFO.
- Issues 64-bit aligned fetch requests to the I-cache and handles redirects from execute/CSR.
- Pushes each returned 64-bit bundle into the FIFO together with its PC, a static 2-bit prediction field and per-slot predecode info.
- A one-entry skid register absorbs a response that arrives while the FIFO cannot accept.

Parameters:
- BOOT_VECTOR, 32'h00000000, PC fetched after reset; bits [1:0] ignored.
- OPC_INFO_W, 10, width of the per-slot predecode info; minimum 6.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- branch_request_i  in  1  redirect strobe from execute/CSR
- branch_pc_i  in  32  redirect target; bits [1:0] ignored
- icache_accept_i  in  1  I-cache accepts a request this cycle
- icache_valid_i  in  1  I-cache response valid (one cycle)
- icache_error_i  in  1  response carries a bus/access fault
- icache_inst_i  in  64  response data; slot0 = [31:0], slot1 = [63:32]
- icache_rd_o  out  1  fetch request
- icache_pc_o  out  32  request address, always {pc[31:3],3'b000}
- icache_flush_o  out  1  one-cycle pulse: abandon the outstanding request
- fetch_accept_i  in  1  FIFO accept_o
- fetch_valid_o  out  1  FIFO push_i
- fetch_pc_o  out  32  bundle PC; bit2 set if the bundle was entered at slot1
- fetch_pred_o  out  2  [0] = slot1 dead; [1] reserved, always 0
- fetch_instr_o  out  64  bundle data
- fetch_info0_o  out  OPC_INFO_W  slot0 predecode
- fetch_info1_o  out  OPC_INFO_W  slot1 predecode

Behaviour:
- Reset values:
  - pc_q = BOOT_VECTOR.
  - State IDLE.
  - All outputs 0 except icache_pc_o = {BOOT_VECTOR[31:3],3'b000}.
  - Skid register empty; drop flag clear.
- IDLE:
  - Entered on reset and on a redirect with nothing outstanding.
  - Moves to REQ the next cycle.
- REQ:
  - icache_rd_o = 1 only when the skid register is empty and fetch_accept_i = 1.
  - On icache_rd_o & icache_accept_i: latch the request PC into req_pc_q, set pc_q = {pc_q[31:3]+1,3'b000}, go to WAIT.
  - Hold request address stable while icache_accept_i = 0.
- WAIT:
  - Exactly one request outstanding.
  - On icache_valid_i, return to REQ; a new request may issue the following cycle, not the same cycle.
- Response routing:
  - If fetch_accept_i = 1 and the skid register is empty, the response drives fetch_* combinationally in the same cycle.
  - Otherwise the response is captured in the skid register.
  - Skid output has priority; fetch_valid_o stays high until fetch_accept_i.
  - Push order is strictly in request order.
- Redirect (branch_request_i; highest priority after reset):
  - pc_q = branch_pc_i with bits [1:0] cleared.
  - Skid register cleared.
  - fetch_valid_o forced 0 that cycle.
  - If in WAIT without icache_valid_i the same cycle: pulse icache_flush_o, set drop flag, stay in WAIT. The response that arrives is discarded, then go to REQ.
  - Redirect coincident with icache_valid_i: the response is discarded and the state goes to REQ.
  - Back-to-back redirects: the last target wins.
- Entry at slot1:
  - After a redirect to an address with bit2 = 1, the first bundle has fetch_pc_o[2] = 1 and info0[5] = 1 (slot0 skip).
  - Subsequent bundles have bit2 = 0.
- Predecode, per slot, over instr[6:0]:
  - info[0] = branch (1100011)
  - info[1] = jal (1101111) or jalr (1100111)
  - info[2] = load or store (0000011 or 0100011)
  - info[3] = mul/div (0110011 with funct7 = 0000001)
  - info[4] = system/csr (1110011)
  - info[5] = skip (slot0 only)
  - Bits above 5 = 0.
- fetch_pred_o[0] = 1 when slot0 is not skipped and info0[1] = 1 (jal/jalr in slot0 kills slot1).
- Fault: icache_error_i forces info0[4] = info1[4] = 1 and fetch_pred_o[0] = 0; the data is passed as received.
- Arithmetic:
  - PC increment is modulo 2^32 (32'hFFFFFFF8 wraps to 0).
  - No other arithmetic.

Test Plan:
- Reset release, BOOT_VECTOR = 32'h80000000, I-cache accepts with 1-cycle latency -> requests 0x80000000, 0x80000008, 0x80000010; one push per response; fetch_pred_o = 0.
- Response arrives while fetch_accept_i = 0 for 3 cycles -> bundle held in the skid register; no new icache_rd_o; pushed exactly once when accept rises; PC sequence unbroken.
- Redirect to 0x80000104 while in WAIT -> icache_flush_o pulse; stale response dropped; next request 0x80000100; first push has fetch_pc_o = 0x80000104 and info0[5] = 1.
- Redirect in the same cycle as icache_valid_i -> response not pushed; next request is the target.
- Slot0 = 32'h0000006F (jal) -> fetch_pred_o = 2'b01, info0[1] = 1; slot1 = 32'h02B50533 (mul) -> info1[3] = 1.
- icache_error_i = 1 on a response -> info0[4] = info1[4] = 1, fetch_pred_o[0] = 0; async reset mid-WAIT -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/fetch_unit.sv
// PC generator and I-cache fetch sequencer feeding the two-slot fetch FIFO.
// One request in flight at a time; a one-entry skid holds a response the FIFO cannot take.
module fetch_unit #(
    parameter logic [31:0] BOOT_VECTOR = 32'h00000000,
    parameter int          OPC_INFO_W  = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  branch_request_i,
    input  logic [31:0]           branch_pc_i,
    input  logic                  icache_accept_i,
    input  logic                  icache_valid_i,
    input  logic                  icache_error_i,
    input  logic [63:0]           icache_inst_i,
    output logic                  icache_rd_o,
    output logic [31:0]           icache_pc_o,
    output logic                  icache_flush_o,
    input  logic                  fetch_accept_i,
    output logic                  fetch_valid_o,
    output logic [31:0]           fetch_pc_o,
    output logic [1:0]            fetch_pred_o,
    output logic [63:0]           fetch_instr_o,
    output logic [OPC_INFO_W-1:0] fetch_info0_o,
    output logic [OPC_INFO_W-1:0] fetch_info1_o
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    typedef struct packed {
        logic [31:0]           pc;
        logic [1:0]            pred;
        logic [63:0]           instr;
        logic [OPC_INFO_W-1:0] info0;
        logic [OPC_INFO_W-1:0] info1;
    } bundle_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] req_pc_q;
    logic        drop_q;
    logic        skid_vld_q;
    bundle_t     skid_q;
    bundle_t     resp_b;
    bundle_t     out_b;
    logic        resp_live;
    logic        skip;

    logic unused_pc_lsb;
    assign unused_pc_lsb = ^branch_pc_i[1:0];

    function automatic logic [OPC_INFO_W-1:0] predecode(input logic [31:0] w);
        logic [OPC_INFO_W-1:0] r;
        r    = '0;
        r[0] = (w[6:0] == 7'b1100011);
        r[1] = (w[6:0] == 7'b1101111) || (w[6:0] == 7'b1100111);
        r[2] = (w[6:0] == 7'b0000011) || (w[6:0] == 7'b0100011);
        r[3] = (w[6:0] == 7'b0110011) && (w[31:25] == 7'b0000001);
        r[4] = (w[6:0] == 7'b1110011);
        return r;
    endfunction

    // A response is only usable if it belongs to the current fetch stream.
    assign resp_live = (state_q == S_WAIT) && icache_valid_i && !drop_q && !branch_request_i;
    assign skip      = req_pc_q[2];

    always_comb begin
        resp_b          = '0;
        resp_b.pc       = req_pc_q;
        resp_b.instr    = icache_inst_i;
        resp_b.info0    = predecode(icache_inst_i[31:0]);
        resp_b.info1    = predecode(icache_inst_i[63:32]);
        resp_b.info0[5] = skip;
        resp_b.pred[0]  = !skip && resp_b.info0[1] && !icache_error_i;
        if (icache_error_i) begin
            resp_b.info0[4] = 1'b1;
            resp_b.info1[4] = 1'b1;
        end
    end

    always_comb begin
        out_b = '0;
        if (skid_vld_q)
            out_b = skid_q;
        else if (resp_live)
            out_b = resp_b;
    end

    assign icache_rd_o    = (state_q == S_REQ) && !skid_vld_q && fetch_accept_i && !branch_request_i;
    assign icache_pc_o    = {pc_q[31:3], 3'b000};
    assign icache_flush_o = branch_request_i && (state_q == S_WAIT) && !icache_valid_i;

    assign fetch_valid_o  = !branch_request_i && (skid_vld_q || (resp_live && fetch_accept_i));
    assign fetch_pc_o     = out_b.pc;
    assign fetch_pred_o   = out_b.pred;
    assign fetch_instr_o  = out_b.instr;
    assign fetch_info0_o  = out_b.info0;
    assign fetch_info1_o  = out_b.info1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            pc_q       <= {BOOT_VECTOR[31:2], 2'b00};
            req_pc_q   <= '0;
            drop_q     <= 1'b0;
            skid_vld_q <= 1'b0;
            skid_q     <= '0;
        end else if (branch_request_i) begin
            pc_q       <= {branch_pc_i[31:2], 2'b00};
            skid_vld_q <= 1'b0;
            case (state_q)
                S_WAIT: begin
                    // With the response still in flight, mark it stale and wait it out.
                    if (icache_valid_i) begin
                        state_q <= S_REQ;
                        drop_q  <= 1'b0;
                    end else begin
                        drop_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end else begin
            if (skid_vld_q && fetch_accept_i)
                skid_vld_q <= 1'b0;
            else if (resp_live && !fetch_accept_i) begin
                skid_vld_q <= 1'b1;
                skid_q     <= resp_b;
            end
            case (state_q)
                S_IDLE: state_q <= S_REQ;
                S_REQ: begin
                    if (icache_rd_o && icache_accept_i) begin
                        req_pc_q <= pc_q;
                        pc_q     <= {pc_q[31:3] + 29'd1, 3'b000};
                        state_q  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (icache_valid_i) begin
                        state_q <= S_REQ;
                        drop_q  <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
